// File: rtl/rggen_bit_field_initiator.sv
// Command-driven initiator for one rggen bit field: one access per command, response on a valid/ready channel.
// Build option: RGGEN_BIT_FIELD_INITIATOR_READBACK_EN adds a READBACK state so write responses carry the post-write field value.
module rggen_bit_field_initiator #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic             i_cmd_write,
    input  logic [WIDTH-1:0] i_cmd_mask,
    input  logic [WIDTH-1:0] i_cmd_data,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_error,
    output logic [WIDTH-1:0] o_rsp_data,
    output logic             o_bf_valid,
    output logic [WIDTH-1:0] o_bf_read_mask,
    output logic [WIDTH-1:0] o_bf_write_mask,
    output logic [WIDTH-1:0] o_bf_write_data,
    input  logic [WIDTH-1:0] i_bf_read_data,
    input  logic [WIDTH-1:0] i_bf_value,
    output logic [1:0]       o_state
);

    // Handshake rule on both channels: a transfer happens at a rising edge where
    // valid and ready are both high; the source holds its payload until then.

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
`ifdef RGGEN_BIT_FIELD_INITIATOR_READBACK_EN
    localparam logic [1:0] READBACK = 2'd2;
`endif
    localparam logic [1:0] RESPOND  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             cmd_write;
    logic [WIDTH-1:0] cmd_mask;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_error;
    logic [WIDTH-1:0] rsp_data;
    logic             mask_zero;
    logic             in_access;

    assign mask_zero = (i_cmd_mask == '0);
    assign in_access = (state == ACCESS);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_cmd_valid) begin
                    state_next = mask_zero ? RESPOND : ACCESS;
                end
            end
            ACCESS: begin
`ifdef RGGEN_BIT_FIELD_INITIATOR_READBACK_EN
                state_next = cmd_write ? READBACK : RESPOND;
`else
                state_next = RESPOND;
`endif
            end
`ifdef RGGEN_BIT_FIELD_INITIATOR_READBACK_EN
            READBACK: begin
                state_next = RESPOND;
            end
`endif
            RESPOND: begin
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cmd_write <= 1'b0;
            cmd_mask  <= '0;
            cmd_data  <= '0;
            rsp_error <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        cmd_write <= i_cmd_write;
                        cmd_mask  <= i_cmd_mask;
                        cmd_data  <= i_cmd_data;
                        rsp_error <= mask_zero;
                        rsp_data  <= '0;
                    end
                end
                ACCESS: begin
                    // Read data is sampled in the strobe cycle, i.e. before the read side-effect lands.
                    rsp_data <= cmd_write ? '0 : (i_bf_read_data & cmd_mask);
                end
`ifdef RGGEN_BIT_FIELD_INITIATOR_READBACK_EN
                READBACK: begin
                    rsp_data <= i_bf_value & cmd_mask;
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifndef RGGEN_BIT_FIELD_INITIATOR_READBACK_EN
    logic unused_bf_value;
    assign unused_bf_value = ^i_bf_value;
`endif

    assign o_cmd_ready     = (state == IDLE);
    assign o_rsp_valid     = (state == RESPOND);
    assign o_rsp_error     = rsp_error;
    assign o_rsp_data      = rsp_data;
    assign o_bf_valid      = in_access;
    assign o_bf_read_mask  = (in_access && !cmd_write) ? cmd_mask : '0;
    assign o_bf_write_mask = (in_access &&  cmd_write) ? cmd_mask : '0;
    assign o_bf_write_data = (in_access &&  cmd_write) ? cmd_data : '0;
    assign o_state         = state;

endmodule
